// File: rtl/cnna_mul_acc_pipe.sv
// -----------------------------------------------------------------------------
// cnna_mul_acc_pipe
//   Pipelined multiplier with a saturating group accumulator on its output.
//   Each valid beat is registered, multiplied (din0 zero- or sign-extended by
//   one bit, din1 signed) and carried through NUM_STAGE stages to dout. Beats
//   flagged acc_en are summed into a saturating accumulator. The beat flagged
//   in_last closes its group and is reported on acc_out/acc_ovf with a
//   one-cycle acc_valid pulse.
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   ce                 clock enable; all state holds while low
//   in_valid           operand beat valid (low = pipeline bubble)
//   in_last            final beat of an accumulation group
//   acc_en             beat takes part in accumulation
//   din0 / din1        operands (din1 always signed)
//   dout, dout_valid   signed product, NUM_STAGE ce edges after sampling
//   acc_out, acc_ovf   group sum and saturation flag, held until next report
//   acc_valid          one-cycle pulse marking a new acc_out
// -----------------------------------------------------------------------------
module cnna_mul_acc_pipe #(
   parameter int DIN0_WIDTH  = 10,
   parameter int DIN1_WIDTH  = 16,
   parameter int DIN0_SIGNED = 0,
   parameter int NUM_STAGE   = 3,
   parameter int ACC_WIDTH   = 32
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   ce,
   input  logic                                   in_valid,
   input  logic                                   in_last,
   input  logic                                   acc_en,
   input  logic        [DIN0_WIDTH-1:0]           din0,
   input  logic signed [DIN1_WIDTH-1:0]           din1,
   output logic signed [DIN0_WIDTH+DIN1_WIDTH-1:0] dout,
   output logic                                   dout_valid,
   output logic signed [ACC_WIDTH-1:0]            acc_out,
   output logic                                   acc_valid,
   output logic                                   acc_ovf
);

   localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

   localparam logic signed [ACC_WIDTH:0] ACC_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH:0] ACC_MIN = {2'b11, {(ACC_WIDTH-1){1'b0}}};

   // ---------------------------------------------------------------- sampling
   logic                         a_sign;
   logic signed [DIN0_WIDTH:0]   a_q;
   logic signed [DIN1_WIDTH-1:0] b_q;
   logic                         cap_v, cap_l, cap_e;

   assign a_sign = (DIN0_SIGNED != 0) ? din0[DIN0_WIDTH-1] : 1'b0;

   // NOTE: sequential state is written only with non-blocking assignments so
   // every register samples the pre-edge value of its neighbour.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q   <= '0;
         b_q   <= '0;
         cap_v <= 1'b0;
         cap_l <= 1'b0;
         cap_e <= 1'b0;
      end else if (ce) begin
         a_q   <= {a_sign, din0};
         b_q   <= din1;
         cap_v <= in_valid;
         cap_l <= in_last;
         cap_e <= acc_en;
      end
   end

   // ---------------------------------------------------------------- multiply
   // Both operands are widened to PW+1 bits so the product is formed at its
   // full signed width; the low PW bits hold the exact result in both modes.
   logic signed [PW:0]   a_x, b_x, prod_full;
   logic signed [PW-1:0] prod;

   assign a_x       = {{DIN1_WIDTH{a_q[DIN0_WIDTH]}}, a_q};
   assign b_x       = {{(DIN0_WIDTH+1){b_q[DIN1_WIDTH-1]}}, b_q};
   assign prod_full = a_x * b_x;
   assign prod      = prod_full[PW-1:0];

   // ---------------------------------------------------------------- pipeline
   logic signed [PW-1:0]  st_data [NUM_STAGE];
   logic [NUM_STAGE-1:0]  st_v, st_l, st_e;

   // NOTE: the data stages are reset too (not only the valids) because dout is
   // a direct view of the last stage and must read zero straight out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NUM_STAGE; k++) st_data[k] <= '0;
         st_v <= '0;
         st_l <= '0;
         st_e <= '0;
      end else if (ce) begin
         st_data[0] <= prod;
         st_v[0]    <= cap_v;
         st_l[0]    <= cap_l;
         st_e[0]    <= cap_e;
         for (int k = 1; k < NUM_STAGE; k++) begin
            st_data[k] <= st_data[k-1];
            st_v[k]    <= st_v[k-1];
            st_l[k]    <= st_l[k-1];
            st_e[k]    <= st_e[k-1];
         end
      end
   end

   assign dout       = st_data[NUM_STAGE-1];
   assign dout_valid = st_v[NUM_STAGE-1];

   // ------------------------------------------------------------- accumulator
   logic                       fire, fire_last;
   logic                       first, grp_ovf, grp_ovf_next, sat_hit;
   logic signed [ACC_WIDTH-1:0] acc_reg, base, acc_sat;
   logic signed [ACC_WIDTH:0]   sum_full;

   assign fire      = dout_valid & st_e[NUM_STAGE-1];
   assign fire_last = fire & st_l[NUM_STAGE-1];

   // NOTE: every variable gets a default at the top of the block, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      base     = first ? '0 : acc_reg;
      sum_full = {base[ACC_WIDTH-1], base} + {{(ACC_WIDTH+1-PW){dout[PW-1]}}, dout};
      acc_sat  = sum_full[ACC_WIDTH-1:0];
      sat_hit  = 1'b0;
      if (sum_full > ACC_MAX) begin
         acc_sat = ACC_MAX[ACC_WIDTH-1:0];
         sat_hit = 1'b1;
      end else if (sum_full < ACC_MIN) begin
         acc_sat = ACC_MIN[ACC_WIDTH-1:0];
         sat_hit = 1'b1;
      end
      // A new group starts with a clean overflow flag.
      grp_ovf_next = (first ? 1'b0 : grp_ovf) | sat_hit;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_reg   <= '0;
         first     <= 1'b1;
         grp_ovf   <= 1'b0;
         acc_out   <= '0;
         acc_valid <= 1'b0;
         acc_ovf   <= 1'b0;
      end else if (ce) begin
         acc_valid <= fire_last;
         if (fire) begin
            acc_reg <= acc_sat;
            grp_ovf <= grp_ovf_next;
            first   <= st_l[NUM_STAGE-1];
            if (st_l[NUM_STAGE-1]) begin
               acc_out <= acc_sat;
               acc_ovf <= grp_ovf_next;
            end
         end
      end
   end

endmodule
